// File: rtl/jtbubl_rom_arb.sv
// ---------------------------------------------------------------------------
// jtbubl_rom_arb
//
// Four-slot ROM read arbiter sitting in front of a single SDRAM read port.
// Each slot owns a one-entry cache (tag, valid, 32-bit data). A slot whose
// current address is not cached raises a miss; misses are granted round-robin
// and fetched one at a time through a simple req/ack/data handshake.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   slotN_cs, slotN_addr  : slot N wants the word at slotN_addr (N = 0..3)
//   slotN_ok, slotN_dout  : cached word is valid for the current address
//   downloading           : ROM load in progress, arbiter idles, caches cleared
//   loop_rst              : clears every slot cache and aborts a fetch
//   sdram_req, sdram_addr : read request towards the SDRAM controller
//   sdram_ack             : controller accepted the request
//   data_rdy, data_read   : requested word is available
//   refresh_en            : controller may run a refresh cycle
// ---------------------------------------------------------------------------
module jtbubl_rom_arb #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          slot0_cs,
    input  logic          slot1_cs,
    input  logic          slot2_cs,
    input  logic          slot3_cs,
    input  logic [AW-1:0] slot0_addr,
    input  logic [AW-1:0] slot1_addr,
    input  logic [AW-1:0] slot2_addr,
    input  logic [AW-1:0] slot3_addr,
    output logic          slot0_ok,
    output logic          slot1_ok,
    output logic          slot2_ok,
    output logic          slot3_ok,
    output logic [31:0]   slot0_dout,
    output logic [31:0]   slot1_dout,
    output logic [31:0]   slot2_dout,
    output logic [31:0]   slot3_dout,

    input  logic          downloading,
    input  logic          loop_rst,

    output logic          sdram_req,
    output logic [AW-1:0] sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [31:0]   data_read,
    output logic          refresh_en
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    state_t        state;
    logic [3:0]    cs;
    logic [3:0]    valid;
    logic [3:0]    ok;
    logic [3:0]    miss;
    logic          any_miss;
    logic          fill;
    logic [1:0]    rr;
    logic [1:0]    grant;
    logic [1:0]    sel;
    logic [AW-1:0] addr [4];
    logic [AW-1:0] tag  [4];
    logic [31:0]   data [4];

    assign cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign addr[3] = slot3_addr;

    always_comb begin
        ok = '0;
        for (int i = 0; i < 4; i++) begin
            ok[i] = cs[i] & valid[i] & (tag[i] == addr[i]);
        end
    end

    assign miss     = cs & ~ok;
    assign any_miss = |miss;

    assign slot0_ok   = ok[0];
    assign slot1_ok   = ok[1];
    assign slot2_ok   = ok[2];
    assign slot3_ok   = ok[3];
    assign slot0_dout = data[0];
    assign slot1_dout = data[1];
    assign slot2_dout = data[2];
    assign slot3_dout = data[3];

    // Scan from the farthest offset back towards rr so that the missing slot
    // closest to rr (wrapping 3->0) is the one left in sel.
    always_comb begin
        sel = rr;
        for (int i = 3; i >= 0; i--) begin
            if (miss[rr + 2'(i)]) begin
                sel = rr + 2'(i);
            end
        end
    end

    // Data may arrive in the same cycle as the ack; both cases fill the cache.
    assign fill = data_rdy & ((state == WAIT_DATA) | ((state == WAIT_ACK) & sdram_ack));

    assign refresh_en = downloading | ((state == IDLE) & ~any_miss);

    // sdram_addr is left untouched until the next grant, so it doubles as the
    // latched tag of the fetch in flight even if the slot address moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            rr         <= 2'd0;
            grant      <= 2'd0;
            valid      <= '0;
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else if (downloading || loop_rst) begin
            valid     <= '0;
            sdram_req <= 1'b0;
            state     <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (any_miss) begin
                        grant      <= sel;
                        sdram_addr <= addr[sel];
                        sdram_req  <= 1'b1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (fill) begin
                data[grant]  <= data_read;
                tag[grant]   <= sdram_addr;
                valid[grant] <= 1'b1;
                rr           <= grant + 2'd1;
                state        <= IDLE;
            end
        end
    end

endmodule

// File: doc/jtbubl_rom_arb.md
JTBUBL_ROM_ARB -- requirements
Module: jtbubl_rom_arb

Interface
- REQ-001 SHALL have parameter AW, default 22: SDRAM word-address width used by every slot address and by sdram_addr.
- REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
- REQ-004 SHALL have ports slotN_cs, input, 1 (N=0..3): slot N requests the word at slotN_addr.
- REQ-005 SHALL have ports slotN_addr, input, AW (N=0..3): SDRAM word address, offset already applied.
- REQ-006 SHALL have ports slotN_ok, output, 1 (N=0..3): slotN_dout is valid for the current slotN_addr.
- REQ-007 SHALL have ports slotN_dout, output, 32 (N=0..3): cached data word for slot N.
- REQ-008 SHALL have port downloading, input, 1: ROM load in progress; arbiter idles and invalidates.
- REQ-009 SHALL have port loop_rst, input, 1: invalidates all slot caches.
- REQ-010 SHALL have port sdram_req, output, 1: read request to the SDRAM controller.
- REQ-011 SHALL have port sdram_addr, output, AW: address of the request.
- REQ-012 SHALL have port sdram_ack, input, 1: controller accepted the request.
- REQ-013 SHALL have port data_rdy, input, 1: data_read holds the requested word.
- REQ-014 SHALL have port data_read, input, 32: SDRAM read data.
- REQ-015 SHALL have port refresh_en, output, 1: controller may refresh.

Function
- REQ-016 SHALL keep, per slot, a one-entry cache: tag (AW bits), valid bit, data (32 bits); slotN_dout SHALL equal the cache data at all times.
- REQ-017 SHALL drive slotN_ok = slotN_cs & validN & (tagN == slotN_addr), combinationally from registered cache state.
- REQ-018 SHALL define missN = slotN_cs & ~slotN_ok.
- REQ-019 SHALL implement FSM IDLE -> WAIT_ACK -> WAIT_DATA -> IDLE.
- REQ-020 In IDLE with any missN, SHALL grant the first missing slot found scanning upward from the rr pointer (wrapping 3->0), then register sdram_addr = granted slot address, latch the address and grant index, set sdram_req=1, and go to WAIT_ACK, all in one cycle.
- REQ-021 In WAIT_ACK, SHALL hold sdram_req and sdram_addr until sdram_ack=1; on sdram_ack it SHALL clear sdram_req and go to WAIT_DATA.
- REQ-022 In WAIT_DATA, on data_rdy it SHALL write data_read, the latched address, and valid=1 into the granted slot's cache, set rr = grant+1 mod 4, and return to IDLE; slotN_ok therefore rises one cycle after data_rdy.
- REQ-023 Data_rdy arriving together with sdram_ack in WAIT_ACK SHALL be treated as ack followed immediately by data: the cache fills and the FSM returns to IDLE.
- REQ-024 If slotN_addr changes or slotN_cs drops mid-fetch, the fetch SHALL still complete into the cache under the latched tag; a new address then misses and is arbitrated afresh.
- REQ-025 The earliest new grant SHALL be the cycle after returning to IDLE, so at most one request is outstanding.
- REQ-026 refresh_en SHALL be 1 only in IDLE with no missN, or while downloading=1; otherwise 0.
- REQ-027 While downloading=1, SHALL hold all valid bits at 0, sdram_req at 0, and the FSM in IDLE, ignoring ack and data_rdy.
- REQ-028 loop_rst=1 SHALL clear all valid bits and force the FSM to IDLE with sdram_req=0.

Reset
- REQ-029 On rst=1 at a clk edge, SHALL set FSM=IDLE, sdram_req=0, sdram_addr=0, rr=0, all valid=0, tags=0, and data=0.
- REQ-030 Consequently, after reset all slotN_ok=0 and slotN_dout=0, and refresh_en=1 until the first miss.
- REQ-031 rst asserted mid-fetch SHALL abandon the fetch, with no cache write even if data_rdy is coincident.

Verification
- REQ-032 Single miss: slot2_cs=1, addr=0x1C000; ack after 3 cycles, data_rdy with 0xDEADBEEF after 5 more -> sdram_addr=0x1C000, slot2_ok=1 and slot2_dout=0xDEADBEEF one cycle after data_rdy.
- REQ-033 Hit: same slot and address re-requested -> slot2_ok=1 combinationally, and sdram_req stays 0.
- REQ-034 Round-robin: all four slots missing simultaneously from reset -> grant order 0,1,2,3; slot0 re-missing after its fill -> served after slot3.
- REQ-035 Address change mid-fetch: slot0 addr 0x100 -> 0x101 during WAIT_DATA -> cache holds 0x100, slot0_ok stays 0, and a second request to 0x101 follows.
- REQ-036 Download/loop_rst: valid caches, then downloading=1 for 10 cycles -> all ok=0, sdram_req=0, refresh_en=1; after release, next cs re-fetches.
- REQ-037 Ack+data coincident, and rst during WAIT_DATA -> REQ-023 and REQ-031 responses respectively.
